mem_access_unit: RTL and testbench

Load/store access unit between the pipeline MEM stage and the word-organised data RAM. Accepts one byte/half/word request at a time over a valid/ready handshake and translates it into a word-aligned RAM access with a byte write mask. For loads it extracts and sign- or zero-extends the addressed lane; for stores it replicates the data across lanes. The RAM side is sequenced so that address, data and mask stay stable across the RAM's registered write-enable edge.

---
 rtl/mem_access_unit_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg : shared sizes, state encoding and bus widths
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_unit_pkg;

   localparam int ADDR_BUS = 32;
   localparam int DATA_BUS = 32;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      WHOLD = 3'd3,
      RESP  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align : byte-mask, store replication, load extract/extend, misalign
// Optional feature macro: MEM_ACCESS_MISALIGN_CHECK_EN
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]          size,
   input  logic [1:0]          offset,
   input  logic                is_signed,
   input  logic [DATA_BUS-1:0] store_data,
   input  logic [DATA_BUS-1:0] load_word,
   output logic [3:0]          mask,
   output logic [DATA_BUS-1:0] store_lanes,
   output logic [DATA_BUS-1:0] load_data,
   output logic                misalign
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Halves use offset[1] only; in the checked build odd offsets never reach here.
   always_comb begin
      mask        = 4'b1111;
      store_lanes = store_data;
      load_data   = load_word;
      byte_sel    = load_word[8*offset +: 8];
      half_sel    = offset[1] ? load_word[31:16] : load_word[15:0];
      case (size)
         SIZE_BYTE: begin
            mask        = 4'b0001 << offset;
            store_lanes = {4{store_data[7:0]}};
            load_data   = {{24{is_signed & byte_sel[7]}}, byte_sel};
         end
         SIZE_HALF: begin
            mask        = offset[1] ? 4'b1100 : 4'b0011;
            store_lanes = {2{store_data[15:0]}};
            load_data   = {{16{is_signed & half_sel[15]}}, half_sel};
         end
         default: ;
      endcase
   end

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
   always_comb begin
      case (size)
         SIZE_BYTE: misalign = 1'b0;
         SIZE_HALF: misalign = offset[0];
         default:   misalign = |offset;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit : MEM-stage load/store sequencer for a word-organised RAM
// Optional feature macro: MEM_ACCESS_MISALIGN_CHECK_EN
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_BUS,
   parameter int DATA_WIDTH = DATA_BUS
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_error,
   output logic                  ram_en,
   output logic [3:0]            ram_write_sel,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   state_t                  state;
   state_t                  next_state;

   logic [1:0]              held_size;
   logic                    held_signed;
   logic [ADDR_WIDTH-1:0]   held_addr;
   logic [DATA_WIDTH-1:0]   held_wdata;
   logic [DATA_WIDTH-1:0]   load_result;
   logic                    error_flag;

   logic                    in_idle;
   logic [1:0]              al_size;
   logic [1:0]              al_offset;
   logic [3:0]              al_mask;
   logic [DATA_WIDTH-1:0]   al_store;
   logic [DATA_WIDTH-1:0]   al_load;
   logic                    al_misalign;
   logic [ADDR_WIDTH-1:0]   word_addr;

   // In IDLE the aligner classifies the incoming request; afterwards the held one.
   assign in_idle   = (state == IDLE);
   assign al_size   = in_idle ? req_size       : held_size;
   assign al_offset = in_idle ? req_addr[1:0]  : held_addr[1:0];
   assign word_addr = {held_addr[ADDR_WIDTH-1:2], 2'b00};

   mem_lane_align u_align (
      .size        (al_size),
      .offset      (al_offset),
      .is_signed   (held_signed),
      .store_data  (held_wdata),
      .load_word   (ram_rdata),
      .mask        (al_mask),
      .store_lanes (al_store),
      .load_data   (al_load),
      .misalign    (al_misalign)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         held_size   <= 2'd0;
         held_signed <= 1'b0;
         held_addr   <= '0;
         held_wdata  <= '0;
         load_result <= '0;
         error_flag  <= 1'b0;
      end else begin
         if (in_idle && req_valid) begin
            held_size   <= req_size;
            held_signed <= req_signed;
            held_addr   <= req_addr;
            held_wdata  <= req_wdata;
            load_result <= '0;
            error_flag  <= al_misalign;
         end
         if (state == READ) begin
            load_result <= al_load;
         end
      end
   end

   always_comb begin
      next_state    = state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_rdata    = '0;
      resp_error    = 1'b0;
      ram_en        = 1'b0;
      ram_write_sel = 4'b0000;
      ram_addr      = '0;
      ram_wdata     = '0;
      case (state)
         IDLE: begin
            // Gated by rst so every output reads 0 while reset is asserted.
            req_ready = rst;
            if (req_valid) begin
               if (al_misalign)    next_state = RESP;
               else if (req_write) next_state = WRITE;
               else                next_state = READ;
            end
         end
         READ: begin
            ram_en     = 1'b1;
            ram_addr   = word_addr;
            next_state = RESP;
         end
         WRITE: begin
            ram_en        = 1'b1;
            ram_write_sel = al_mask;
            ram_addr      = word_addr;
            ram_wdata     = al_store;
            next_state    = WHOLD;
         end
         WHOLD: begin
            ram_write_sel = al_mask;
            ram_addr      = word_addr;
            ram_wdata     = al_store;
            next_state    = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = load_result;
            resp_error = error_flag;
            if (resp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit : directed + random load/store bench with byte-array model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        ram_en;
   logic [3:0]  ram_write_sel;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] ram_word [0:63];
   logic [7:0]  ref_mem  [0:255];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_size      (req_size),
      .req_signed    (req_signed),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_rdata    (resp_rdata),
      .resp_error    (resp_error),
      .ram_en        (ram_en),
      .ram_write_sel (ram_write_sel),
      .ram_addr      (ram_addr),
      .ram_wdata     (ram_wdata),
      .ram_rdata     (ram_rdata)
   );

   // RAM: combinational read, byte-masked write on the enabled rising edge.
   assign ram_rdata = ram_word[ram_addr[7:2]];
   always @(posedge clk) begin
      if (ram_en) begin
         for (int i = 0; i < 4; i++) begin
            if (ram_write_sel[i]) ram_word[ram_addr[7:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"},  32'(req_ready),     32'd0);
      check({tag, "_resp_valid"}, 32'(resp_valid),    32'd0);
      check({tag, "_resp_rdata"}, resp_rdata,         32'd0);
      check({tag, "_resp_error"}, 32'(resp_error),    32'd0);
      check({tag, "_ram_en"},     32'(ram_en),        32'd0);
      check({tag, "_ram_sel"},    32'(ram_write_sel), 32'd0);
      check({tag, "_ram_addr"},   ram_addr,           32'd0);
      check({tag, "_ram_wdata"},  ram_wdata,          32'd0);
   endtask

   // One complete request/response, checked cycle by cycle against the byte model.
   task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input int hold);
      int          n;
      int          oe;
      int          base;
      int          lat;
      int          cyc;
      logic        err;
      logic [3:0]  exp_mask;
      logic [31:0] exp_wd;
      logic [31:0] exp_rd;
      logic [31:0] word_a;

      n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      oe   = (n == 4) ? 0 : (n == 2) ? (a[1] ? 2 : 0) : int'(a[1:0]);
      base = int'({a[7:2], 2'b00});
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      err  = (int'(a[1:0]) % n) != 0;
`else
      err  = 1'b0;
`endif
      word_a   = {a[31:2], 2'b00};
      exp_mask = 4'(((1 << n) - 1) << oe);
      exp_wd   = (n == 1) ? {24'd0, d[7:0]}  * 32'h0101_0101 :
                 (n == 2) ? {16'd0, d[15:0]} * 32'h0001_0001 : d;
      exp_rd   = 32'd0;
      if (!err && !w) begin
         for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(ref_mem[base + oe + i]) << (8 * i));
         if (sg && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'd1 << (8 * n)) - 32'd1);
      end
      lat = err ? 1 : (w ? 3 : 2);

      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      @(negedge clk);
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;

      cyc = 1;
      while (!resp_valid && cyc <= 4) begin
         check("busy_req_ready", 32'(req_ready), 32'd0);
         check("ram_addr", ram_addr, word_a);
         if (!w) begin
            check("rd_en",  32'(ram_en),        32'd1);
            check("rd_sel", 32'(ram_write_sel), 32'd0);
         end else begin
            check("wr_en",    32'(ram_en),        (cyc == 1) ? 32'd1 : 32'd0);
            check("wr_mask",  32'(ram_write_sel), 32'(exp_mask));
            check("wr_wdata", ram_wdata,          exp_wd);
         end
         @(negedge clk);
         cyc++;
      end
      check("latency", 32'(cyc), 32'(lat));

      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_rdata", resp_rdata,      exp_rd);
      check("resp_error", 32'(resp_error), 32'(err));
      check("resp_ram_en",  32'(ram_en),        32'd0);
      check("resp_ram_sel", 32'(ram_write_sel), 32'd0);
      check("resp_ram_addr", ram_addr,          32'd0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_valid",     32'(resp_valid), 32'd1);
         check("hold_rdata",     resp_rdata,      exp_rd);
         check("hold_error",     32'(resp_error), 32'(err));
         check("hold_req_ready", 32'(req_ready),  32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("after_resp_valid", 32'(resp_valid), 32'd0);

      if (w && !err) begin
         for (int i = 0; i < n; i++) ref_mem[base + oe + i] = d[8*i +: 8];
      end
   endtask

   initial begin
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      resp_ready = 1'b0;
      for (int i = 0; i < 64; i++)  ram_word[i] = 32'd0;
      for (int i = 0; i < 256; i++) ref_mem[i]  = 8'd0;

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      #1;
      check("post_reset_ready", 32'(req_ready), 32'd1);

      // Word store then load
      access(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0);
      access(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0);
      // Byte lanes
      access(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h1234_5680, 0);
      access(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 0);
      access(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 0);
      // Half store/load
      access(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'hAAAA_1234, 0);
      access(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 0);
      access(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_8001, 0);
      access(1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0, 0);
      access(1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0, 0);
      // Offset-misaligned and reserved-size requests
      access(1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0, 0);
      access(1'b1, 2'd1, 1'b0, 32'h0000_0031, 32'h0000_7E7E, 0);
      access(1'b0, 2'd3, 1'b1, 32'h0000_0030, 32'h0, 0);
      // High address bits pass straight through
      access(1'b0, 2'd0, 1'b1, 32'hFFFF_FF13, 32'h0, 0);
      // Back-pressure
      access(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 5);

      // Reset in WHOLD
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
      req_addr  = 32'h0000_0040; req_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("whold_en",   32'(ram_en),        32'd0);
      check("whold_mask", 32'(ram_write_sel), 32'hF);
      rst = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk);
      check_all_zero("held_reset");
      rst = 1'b1;
      #1;
      check("release_ready", 32'(req_ready),  32'd1);
      check("release_resp",  32'(resp_valid), 32'd0);
      access(1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 0);
      access(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 0);

      // Randomized traffic
      for (int t = 0; t < 120; t++) begin
         access(1'($urandom), 2'($urandom), 1'($urandom),
                {$urandom_range(0, 255) == 0 ? 24'hFFFFFF : 24'($urandom), 8'($urandom)},
                $urandom, int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
